piso_serializer: RTL
====================

# piso_serializer

Parallel-in/serial-out stage that feeds the serial pattern-detector FSM. It accepts W-bit words over a valid/ready handshake and shifts them out one bit per clock on `sout`, which drives the detector's `I` input. It supports back-to-back words with no idle bit between them. When idle it holds the line at 0.

## Interface
- `W`, default 8: word width in bits, W ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts bit W-1 first, 0 shifts bit 0 first.

- `clk`  in  1  sole clock; all logic on rising edge.
- `R`  in  1  reset, synchronous, active-high.
- `din`  in  W  parallel word; sampled only on an accept edge.
- `load`  in  1  word-valid from the producer.
- `ready`  out  1  stage can accept a word this cycle.
- `sout`  out  1  serial bit, registered; connects to detector `I`.
- `sval`  out  1  high while `sout` carries a data bit.
- `last`  out  1  high during the cycle `sout` carries the final bit of a word.

## Operation
- State machine has two states, IDLE and SHIFT, plus a bit counter `cnt` of width clog2(W) and a W-bit shift register.
- Accept is the rising edge where `load && ready`. The core samples `din` only on that edge.
- `ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when `cnt == W-1`, which gives gapless streaming.
  - 0 otherwise.
- IDLE with accept:
  - Load the shift register from `din`.
  - `sout` <= first bit (din[W-1] if MSB_FIRST, else din[0]).
  - `sval` <= 1, `cnt` <= 0, go to SHIFT.
- IDLE without accept: `sout` = 0, `sval` = 0, `last` = 0. Stay in IDLE.
- SHIFT with `cnt < W-1`: shift one position, `sout` <= next bit, `cnt` <= `cnt`+1. `last` <= 1 when the new `cnt` equals W-1.
- SHIFT with `cnt == W-1`:
  - If accept: reload as in the IDLE-accept case and stay in SHIFT. The first bit of the new word follows the last bit of the old word on the very next cycle.
  - Otherwise: go to IDLE, with `sout` <= 0, `sval` <= 0, `last` <= 0.
- While `ready` = 0, the core ignores `load` and `din` changes. No word is dropped or queued; the producer must hold `load` until it sees `ready`.
- `sout` and `sval` always change on the same edge. `sout` is 0 whenever `sval` = 0.

## Timing
- Reset (R = 1 at an edge), including mid-word:
  - State goes to IDLE, `cnt` = 0, shift register = 0.
  - `sout` = 0, `sval` = 0, `last` = 0, `ready` = 1.
  - A partial word is abandoned; no `last` is emitted for it.
- R has priority over `load` on the same edge.
- Latency: with accept at edge k, bit 0 of the serial order is on `sout` from edge k through edge k+1. Bit j is valid in the cycle after edge k+j.
- `last` is high in the cycle after edge k+W-1.
- Throughput: one word every W cycles when `load` is held high.
- An isolated word occupies exactly W cycles of `sval` = 1.

## Test plan
- Reset: R = 1 for 2 edges with `load` = 1, then R = 0 -> `sout` = 0, `sval` = 0, `last` = 0, `ready` = 1 after each reset edge. No word is accepted while R = 1.
- Single word: W = 8, MSB_FIRST = 1, `din` = 8'hA5, `load` pulsed for 1 cycle ->
  - `sout` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - `sval` high for exactly those 8 cycles; `last` high only on the 8th.
  - `ready` = 0 on cycles 1-7; then back to IDLE with `sout` = 0.
- Back-to-back: `din` = 8'hF0 then 8'h0F, `load` held high -> 16 contiguous `sval` cycles, `sout` = 1111000000001111. `last` is high on cycles 8 and 16; `ready` is high on cycle 8.
- LSB first: MSB_FIRST = 0, `din` = 8'h01 -> `sout` = 1,0,0,0,0,0,0,0.
- Reset mid-word: assert R during bit 4 of 8'hFF -> next cycle `sout` = 0, `sval` = 0, `last` never asserts. A new word 8'h80 accepted afterwards serializes correctly.
- Held `load` while busy: change `din` during SHIFT with `load` = 1 -> the output word is unaffected. The new `din` is taken only at `cnt == W-1`.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts W-bit words on a load/ready handshake and
// shifts them out one bit per clock, back-to-back without idle bits.
module piso_serializer #(
    parameter int unsigned W         = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         R,
    input  logic [W-1:0] din,
    input  logic         load,
    output logic         ready,
    output logic         sout,
    output logic         sval,
    output logic         last
);

    localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic [W-1:0]  r_shreg;
    logic [W-1:0]  w_shreg_n;
    logic          r_sout;
    logic          w_sout_n;
    logic          r_sval;
    logic          w_sval_n;
    logic          r_last;
    logic          w_last_n;

    logic          w_ready;
    logic          w_accept;
    logic          w_first_bit;
    logic          w_next_bit;
    logic [W-1:0]  w_shifted;

    // Ready in IDLE, or on the final bit of a word so the next word follows gaplessly.
    assign w_ready  = (r_state == ST_IDLE) || (r_cnt == LAST_CNT);
    assign w_accept = load && w_ready;

    // Bit-order selection: the register always shifts toward the outgoing end.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign w_first_bit = din[W-1];
            assign w_next_bit  = r_shreg[W-2];
            assign w_shifted   = {r_shreg[W-2:0], 1'b0};
        end else begin : g_lsb
            assign w_first_bit = din[0];
            assign w_next_bit  = r_shreg[1];
            assign w_shifted   = {1'b0, r_shreg[W-1:1]};
        end
    endgenerate

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_sout  <= 1'b0;
            r_sval  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_shreg <= w_shreg_n;
            r_sout  <= w_sout_n;
            r_sval  <= w_sval_n;
            r_last  <= w_last_n;
        end
    end

    // Next-state and next-output logic; the line idles at 0 unless a bit is being sent.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_shreg_n = r_shreg;
        w_sout_n  = 1'b0;
        w_sval_n  = 1'b0;
        w_last_n  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_n = ST_SHIFT;
                    w_shreg_n = din;
                    w_sout_n  = w_first_bit;
                    w_sval_n  = 1'b1;
                    w_cnt_n   = '0;
                end
            end
            ST_SHIFT: begin
                if (r_cnt != LAST_CNT) begin
                    w_shreg_n = w_shifted;
                    w_sout_n  = w_next_bit;
                    w_sval_n  = 1'b1;
                    w_cnt_n   = CW'(r_cnt + CW'(1));
                    w_last_n  = (w_cnt_n == LAST_CNT);
                end else if (w_accept) begin
                    w_shreg_n = din;
                    w_sout_n  = w_first_bit;
                    w_sval_n  = 1'b1;
                    w_cnt_n   = '0;
                end else begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = '0;
                end
            end
        endcase
    end

    assign ready = w_ready;
    assign sout  = r_sout;
    assign sval  = r_sval;
    assign last  = r_last;

endmodule
